multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Sequencing controller for the multicycle MIPS datapath (shared memory, IR, ALU/ULA, regfile, PC).
//  Decodes OP/Funct from the IR and steps the datapath through fetch/decode/execute/mem/writeback.
//  Emits one cycle's datapath control per state and stalls on a memory-ready handshake.
//  Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j. Flags anything else as illegal.
// PARAMETERS
//  (none; all encodings are fixed constants in ctrl_pkg)
// PORTS
//  clk          in   1  rising-edge clock, single clock domain
//  reset        in   1  synchronous, active-high reset
//  OP           in   6  IR[31:26], valid from DECODE onward
//  Funct        in   6  IR[5:0], valid from DECODE onward
//  Zero         in   1  ULA zero flag, sampled in BRANCH
//  mem_ready    in   1  memory accepts/returns this cycle
//  IorD         out  1  memory address mux: 0=PC, 1=ALUOut
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  load IR with memory read data
//  RegDst       out  1  write register: 0=rt, 1=rd
//  MemtoReg     out  1  write-back data: 0=ALUOut, 1=MDR
//  RegWrite     out  1  register file write enable
//  ULASrcA      out  1  A operand: 0=PC, 1=regA
//  ULASrcB      out  2  B operand: 00=regB, 01=4, 10=signimm, 11=signimm<<2
//  ULAControl   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  PCSrc        out  2  00=ULA result, 01=ALUOut, 10=jump target
//  PCEn         out  1  PCWrite | (Branch & Zero)
//  instr_done   out  1  1-cycle pulse in the final state of each retired instruction
//  illegal_instr out 1  1-cycle pulse in DECODE on an unsupported OP/Funct
// BEHAVIOUR
//  Reset
//   - State register -> FETCH on any edge with reset=1.
//   - While reset=1, every output is forced to 0 (including PCEn and both pulses).
//   - Reset asserted mid-instruction aborts it; no partial write-back occurs.
//  Outputs
//   - Moore-decoded from the state register, with the two gates below.
//   - Any signal not listed for a state is 0.
//  States and transitions
//   - FETCH: IorD=0, ULASrcA=0, ULASrcB=01, ULAControl=add, PCSrc=00.
//     IRWrite=PCWrite=mem_ready. Holds while mem_ready=0, then -> DECODE.
//   - DECODE: ULASrcA=0, ULASrcB=11, ULAControl=add (branch target precompute).
//     Next state by OP: lw/sw -> MEMADR; R-type with legal Funct -> EXECUTE; beq -> BRANCH;
//     addi -> ADDIEX; j -> JUMP. Otherwise illegal_instr=1 and -> FETCH.
//   - MEMADR: ULASrcA=1, ULASrcB=10, add. lw -> MEMRD, sw -> MEMWR.
//   - MEMRD: IorD=1. Holds until mem_ready=1, then -> MEMWB.
//   - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
//   - MEMWR: IorD=1, MemWrite=1, held until the mem_ready=1 cycle; instr_done=1 in that cycle -> FETCH.
//   - EXECUTE: ULASrcA=1, ULASrcB=00, ULAControl from Funct -> ALUWB.
//   - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
//   - BRANCH: ULASrcA=1, ULASrcB=00, sub, PCSrc=01, Branch=1, instr_done=1 -> FETCH.
//   - ADDIEX: ULASrcA=1, ULASrcB=10, add -> ADDIWB.
//   - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
//   - JUMP: PCSrc=10, PCWrite=1, instr_done=1 -> FETCH.
//  Latency (mem_ready tied 1)
//   - lw=5, sw=4, R=4, addi=4, beq=3, j=3 cycles.
//   - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
//  Handshake
//   - mem_ready is ignored outside FETCH/MEMRD/MEMWR.
//   - MemWrite never pulses more than one accepted cycle per sw.
//  Undefined encodings
//   - Unreachable state encodings -> FETCH on the next edge, all outputs 0.
// STRUCTURE
//  ctrl_pkg
//   - state_t enum; OP_* and FUNCT_* constants; ULA_ADD/SUB/AND/OR/SLT codes; ULASrcB/PCSrc codes.
//  ula_funct_decoder
//   - Combinational Funct -> {ULAControl, legal}; used in DECODE (legality) and EXECUTE.
//  Top level
//   - State register, next-state logic and output decode.
// TESTING
//  1. Reset held 3 cycles mid-lw (in MEMRD) -> all outputs 0 during reset; FETCH with IRWrite=1 on the first cycle after release.
//  2. lw (OP=100011), mem_ready=1 -> 5 cycles. RegWrite,MemtoReg=1 in cycle 5. instr_done exactly once.
//  3. sw, mem_ready low for 2 cycles in MEMWR -> MemWrite high 3 cycles; instr_done only in the ready cycle; 6 cycles total.
//  4. R-type Funct=100010/101010 -> ULAControl 110/111 in EXECUTE; RegDst=1 in ALUWB.
//  5. beq with Zero=1 vs Zero=0 -> PCEn=1/0 in BRANCH with PCSrc=01. j -> PCSrc=10, PCEn=1.
//  6. OP=111111 and R-type Funct=000111 -> illegal_instr pulse in DECODE; back to FETCH; no RegWrite/MemWrite.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// values, ULA operation codes, operand/PC mux selects and the control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw per-state control; PCEn is derived from pcwrite/branch at the top level.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       ulasrca;
        logic [1:0] ulasrcb;
        logic [2:0] ulacontrol;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       instr_done;
        logic       illegal_instr;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ula_funct_decoder.sv
// Combinational R-type Funct decoder: yields the ULA operation and whether the
// Funct field is one the controller supports.
module ula_funct_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] ula_control,
    output logic       legal
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ula_control = ULA_ADD;
        legal       = 1'b1;
        case (funct)
            FUNCT_ADD: ula_control = ULA_ADD;
            FUNCT_SUB: ula_control = ULA_SUB;
            FUNCT_AND: ula_control = ULA_AND;
            FUNCT_OR:  ula_control = ULA_OR;
            FUNCT_SLT: ula_control = ULA_SLT;
            default:   legal       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: steps the shared datapath through
// fetch/decode/execute/memory/writeback, stalling on the memory handshake.
module multicycle_control_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [2:0] ULAControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t     state;
    state_t     next_state;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [2:0] funct_ula;
    logic       funct_legal;

    ula_funct_decoder u_funct_dec (
        .funct       (Funct),
        .ula_control (funct_ula),
        .legal       (funct_legal)
    );

    // NOTE: sequential state uses non-blocking assignment; reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        ctrl       = '0;
        case (state)
            FETCH: begin
                ctrl.ulasrcb    = SRCB_FOUR;
                ctrl.ulacontrol = ULA_ADD;
                ctrl.pcsrc      = PCSRC_ULA;
                ctrl.irwrite    = mem_ready;
                ctrl.pcwrite    = mem_ready;
                next_state      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl.ulasrcb    = SRCB_IMM_SH;
                ctrl.ulacontrol = ULA_ADD;
                if (is_mem_op(OP)) begin
                    next_state = MEMADR;
                end else begin
                    case (OP)
                        OP_RTYPE: begin
                            if (funct_legal) begin
                                next_state = EXECUTE;
                            end else begin
                                ctrl.illegal_instr = 1'b1;
                                next_state         = FETCH;
                            end
                        end
                        OP_BEQ:  next_state = BRANCH;
                        OP_ADDI: next_state = ADDIEX;
                        OP_J:    next_state = JUMP;
                        default: begin
                            ctrl.illegal_instr = 1'b1;
                            next_state         = FETCH;
                        end
                    endcase
                end
            end
            MEMADR: begin
                ctrl.ulasrca    = 1'b1;
                ctrl.ulasrcb    = SRCB_IMM;
                ctrl.ulacontrol = ULA_ADD;
                next_state      = (OP == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.iord  = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                next_state      = FETCH;
            end
            MEMWR: begin
                // The strobe is held while memory stalls; only the ready cycle is accepted.
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = mem_ready;
                next_state      = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ctrl.ulasrca    = 1'b1;
                ctrl.ulasrcb    = SRCB_REGB;
                ctrl.ulacontrol = funct_ula;
                next_state      = ALUWB;
            end
            ALUWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                next_state      = FETCH;
            end
            BRANCH: begin
                ctrl.ulasrca    = 1'b1;
                ctrl.ulasrcb    = SRCB_REGB;
                ctrl.ulacontrol = ULA_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
                next_state      = FETCH;
            end
            ADDIEX: begin
                ctrl.ulasrca    = 1'b1;
                ctrl.ulasrcb    = SRCB_IMM;
                ctrl.ulacontrol = ULA_ADD;
                next_state      = ADDIWB;
            end
            ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
                next_state      = FETCH;
            end
            JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
                next_state      = FETCH;
            end
            default: begin
                ctrl       = '0;
                next_state = FETCH;
            end
        endcase
    end

    // Reset masks the whole control word so an aborted instruction writes nothing.
    assign ctrl_out = reset ? '0 : ctrl;

    assign IorD          = ctrl_out.iord;
    assign MemWrite      = ctrl_out.memwrite;
    assign IRWrite       = ctrl_out.irwrite;
    assign RegDst        = ctrl_out.regdst;
    assign MemtoReg      = ctrl_out.memtoreg;
    assign RegWrite      = ctrl_out.regwrite;
    assign ULASrcA       = ctrl_out.ulasrca;
    assign ULASrcB       = ctrl_out.ulasrcb;
    assign ULAControl    = ctrl_out.ulacontrol;
    assign PCSrc         = ctrl_out.pcsrc;
    assign PCEn          = ctrl_out.pcwrite | (ctrl_out.branch & Zero);
    assign instr_done    = ctrl_out.instr_done;
    assign illegal_instr = ctrl_out.illegal_instr;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus pushes the expected
// per-cycle control word, a monitor pops and compares it every cycle.
module tb_multicycle_control_fsm;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [5:0] OP        = 6'b0;
    logic [5:0] Funct     = 6'b0;
    logic       Zero      = 1'b0;
    logic       mem_ready = 1'b1;

    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA;
    logic [1:0] ULASrcB;
    logic [2:0] ULAControl;
    logic [1:0] PCSrc;
    logic       PCEn, instr_done, illegal_instr;

    multicycle_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .OP            (OP),
        .Funct         (Funct),
        .Zero          (Zero),
        .mem_ready     (mem_ready),
        .IorD          (IorD),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .ULASrcA       (ULASrcA),
        .ULASrcB       (ULASrcB),
        .ULAControl    (ULAControl),
        .PCSrc         (PCSrc),
        .PCEn          (PCEn),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    // Word layout: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ULASrcA _ ULASrcB _ ULAControl _ PCSrc _ PCEn instr_done illegal_instr
    logic [16:0] got;
    assign got = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA,
                  ULASrcB, ULAControl, PCSrc, PCEn, instr_done, illegal_instr};

    localparam logic [16:0] W_ZERO       = 17'b0000000_00_000_00_000;
    localparam logic [16:0] W_FETCH      = 17'b0010000_01_010_00_100;
    localparam logic [16:0] W_FETCH_WAIT = 17'b0000000_01_010_00_000;
    localparam logic [16:0] W_DECODE     = 17'b0000000_11_010_00_000;
    localparam logic [16:0] W_DECODE_ILL = 17'b0000000_11_010_00_001;
    localparam logic [16:0] W_MEMADR     = 17'b0000001_10_010_00_000;
    localparam logic [16:0] W_MEMRD      = 17'b1000000_00_000_00_000;
    localparam logic [16:0] W_MEMWB      = 17'b0000110_00_000_00_010;
    localparam logic [16:0] W_MEMWR_WAIT = 17'b1100000_00_000_00_000;
    localparam logic [16:0] W_MEMWR_DONE = 17'b1100000_00_000_00_010;
    localparam logic [16:0] W_EXEC_SUB   = 17'b0000001_00_110_00_000;
    localparam logic [16:0] W_EXEC_SLT   = 17'b0000001_00_111_00_000;
    localparam logic [16:0] W_ALUWB      = 17'b0001010_00_000_00_010;
    localparam logic [16:0] W_BR_TAKEN   = 17'b0000001_00_110_01_110;
    localparam logic [16:0] W_BR_NOT     = 17'b0000001_00_110_01_010;
    localparam logic [16:0] W_ADDIEX     = 17'b0000001_10_010_00_000;
    localparam logic [16:0] W_ADDIWB     = 17'b0000010_00_000_00_010;
    localparam logic [16:0] W_JUMP       = 17'b0000000_00_000_10_110;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD_OP = 6'b111111;
    localparam logic [5:0] F_SUB = 6'b100010, F_SLT = 6'b101010, F_BAD = 6'b000111;

    typedef struct {
        logic [16:0] word;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    task automatic step(input logic rst, input logic rdy, input logic z,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [16:0] w, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = rdy;
        Zero      = z;
        OP        = op;
        Funct     = fn;
        e.word    = w;
        e.name    = nm;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (got !== e.word) begin
                    failures++;
                    $display("FAIL %s (cycle %0d): got %b expected %b", e.name, cycle, got, e.word);
                end
            end
        end
    end

    initial begin : stimulus
        step(1, 1, 0, RT, 0, W_ZERO, "reset_0");
        step(1, 1, 0, RT, 0, W_ZERO, "reset_1");

        // lw, no stalls: 5 cycles
        step(0, 1, 0, LW, 0, W_FETCH,  "lw_fetch");
        step(0, 1, 0, LW, 0, W_DECODE, "lw_decode");
        step(0, 1, 0, LW, 0, W_MEMADR, "lw_memadr");
        step(0, 1, 0, LW, 0, W_MEMRD,  "lw_memrd");
        step(0, 1, 0, LW, 0, W_MEMWB,  "lw_memwb");

        // fetch stall, then sw with two write stalls: 6 cycles after fetch accept
        step(0, 0, 0, SW, 0, W_FETCH_WAIT, "sw_fetch_wait");
        step(0, 1, 0, SW, 0, W_FETCH,      "sw_fetch");
        step(0, 1, 0, SW, 0, W_DECODE,     "sw_decode");
        step(0, 1, 0, SW, 0, W_MEMADR,     "sw_memadr");
        step(0, 0, 0, SW, 0, W_MEMWR_WAIT, "sw_memwr_wait0");
        step(0, 0, 0, SW, 0, W_MEMWR_WAIT, "sw_memwr_wait1");
        step(0, 1, 0, SW, 0, W_MEMWR_DONE, "sw_memwr_done");

        // R-type sub and slt
        step(0, 1, 0, RT, F_SUB, W_FETCH,    "sub_fetch");
        step(0, 1, 0, RT, F_SUB, W_DECODE,   "sub_decode");
        step(0, 1, 0, RT, F_SUB, W_EXEC_SUB, "sub_execute");
        step(0, 1, 0, RT, F_SUB, W_ALUWB,    "sub_aluwb");
        step(0, 1, 0, RT, F_SLT, W_FETCH,    "slt_fetch");
        step(0, 1, 0, RT, F_SLT, W_DECODE,   "slt_decode");
        step(0, 1, 0, RT, F_SLT, W_EXEC_SLT, "slt_execute");
        step(0, 1, 0, RT, F_SLT, W_ALUWB,    "slt_aluwb");

        // addi with mem_ready low where it must be ignored
        step(0, 1, 0, ADDI, 0, W_FETCH,  "addi_fetch");
        step(0, 0, 0, ADDI, 0, W_DECODE, "addi_decode");
        step(0, 0, 0, ADDI, 0, W_ADDIEX, "addi_ex");
        step(0, 0, 0, ADDI, 0, W_ADDIWB, "addi_wb");

        // beq taken / not taken, then j
        step(0, 1, 1, BEQ, 0, W_FETCH,    "beq1_fetch");
        step(0, 1, 1, BEQ, 0, W_DECODE,   "beq1_decode");
        step(0, 1, 1, BEQ, 0, W_BR_TAKEN, "beq1_branch");
        step(0, 1, 0, BEQ, 0, W_FETCH,    "beq0_fetch");
        step(0, 1, 0, BEQ, 0, W_DECODE,   "beq0_decode");
        step(0, 1, 0, BEQ, 0, W_BR_NOT,   "beq0_branch");
        step(0, 1, 0, J,   0, W_FETCH,    "j_fetch");
        step(0, 1, 0, J,   0, W_DECODE,   "j_decode");
        step(0, 1, 0, J,   0, W_JUMP,     "j_jump");

        // illegal opcode and illegal R-type funct
        step(0, 1, 0, BAD_OP, 0,     W_FETCH,      "badop_fetch");
        step(0, 1, 0, BAD_OP, 0,     W_DECODE_ILL, "badop_decode");
        step(0, 1, 0, RT,     F_BAD, W_FETCH,      "badfn_fetch");
        step(0, 1, 0, RT,     F_BAD, W_DECODE_ILL, "badfn_decode");

        // lw aborted by reset while stalled in MEMRD
        step(0, 1, 0, LW, 0, W_FETCH,  "abort_fetch");
        step(0, 1, 0, LW, 0, W_DECODE, "abort_decode");
        step(0, 1, 0, LW, 0, W_MEMADR, "abort_memadr");
        step(0, 0, 0, LW, 0, W_MEMRD,  "abort_memrd_wait");
        step(1, 1, 0, LW, 0, W_ZERO,   "abort_reset0");
        step(1, 1, 0, LW, 0, W_ZERO,   "abort_reset1");
        step(1, 1, 0, LW, 0, W_ZERO,   "abort_reset2");
        step(0, 1, 0, J,  0, W_FETCH,  "post_reset_fetch");
        step(0, 1, 0, J,  0, W_DECODE, "post_reset_decode");
        step(0, 1, 0, J,  0, W_JUMP,   "post_reset_jump");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
